// File: rtl/sec_a2b_sched_if.sv
// Requester-side bundle for sec_a2b_sched.
//   master : requesters (drive req_vld/req_a/rsp_rdy)
//   slave  : scheduler  (drives req_rdy/rsp_vld/rsp_z)
//   req_vld/req_rdy : operand handshake, one bit per requester
//   req_a           : per-requester 4-share arithmetic-masked operand
//   rsp_vld/rsp_rdy : result handshake, one bit per requester
//   rsp_z           : Boolean-masked result, shared by all requesters
interface sec_a2b_sched_if #(
    parameter int N_REQ     = 2,
    parameter int MASKWIDTH = 128
);
    logic [N_REQ-1:0]                req_vld;
    logic [N_REQ-1:0]                req_rdy;
    logic [N_REQ-1:0][MASKWIDTH-1:0] req_a;
    logic [N_REQ-1:0]                rsp_vld;
    logic [N_REQ-1:0]                rsp_rdy;
    logic [MASKWIDTH-1:0]            rsp_z;

    modport master (output req_vld, req_a, rsp_rdy,
                    input  req_rdy, rsp_vld, rsp_z);
    modport slave  (input  req_vld, req_a, rsp_rdy,
                    output req_rdy, rsp_vld, rsp_z);
endinterface

// File: rtl/sec_a2b_sched.sv
// sec_a2b_sched: issue controller / round-robin arbiter sharing one masked
// arithmetic-to-Boolean pipeline (fixed PIPE_LAT enabled-cycle latency)
// between N_REQ requesters. Each issue is tagged; tags travel in a shadow
// pipe that advances with the datapath so results route back in order.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rq (slave)      : requester operand/result handshakes (sec_a2b_sched_if)
//   rnd_vld/rnd_take: PRNG fresh-word available / consumed
//   dp_dvld/dp_ena/dp_a : to datapath dvld / ena / i_a
//   dp_ovld/dp_z    : from datapath ovld / o_z (held while ena=0)
//   flush/flush_done: drain request / one-cycle completion pulse
//   busy            : entries in flight or not in RUN
//   err             : sticky tag-vs-dp_ovld mismatch
//
// Build option: SEC_A2B_SCRUB_EN adds a SCRUB state after DRAIN that pushes
// PIPE_LAT zero operands through the datapath to overwrite residual shares.
module sec_a2b_sched #(
    parameter int K_WIDTH   = 32,
    parameter int N_SHARES  = 4,
    parameter int N_REQ     = 2,
    parameter int PIPE_LAT  = 10,
    parameter int MASKWIDTH = K_WIDTH * N_SHARES,
    parameter int TW        = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    sec_a2b_sched_if.slave       rq,
    input  logic                 rnd_vld,
    output logic                 rnd_take,
    output logic                 dp_dvld,
    output logic                 dp_ena,
    output logic [MASKWIDTH-1:0] dp_a,
    input  logic                 dp_ovld,
    input  logic [MASKWIDTH-1:0] dp_z,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 busy,
    output logic                 err
);

`ifdef SEC_A2B_SCRUB_EN
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SCRUB, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
`endif

    state_t                      state_q, state_d;
    // Tag shadow pipe: index PIPE_LAT-1 is the head, aligned with dp_ovld/dp_z.
    logic [PIPE_LAT-1:0]         pv_q, pv_d;
    logic [PIPE_LAT-1:0][TW-1:0] pt_q, pt_d;
    logic [TW-1:0]               ptr_q, ptr_d;
    logic                        err_q, err_d;

    logic          head_vld, head_blk, any_vld, issue, in_scrub, pipe_busy;
    logic [TW-1:0] head_tag, win, win_nxt;

    assign head_vld  = pv_q[PIPE_LAT-1];
    assign head_tag  = pt_q[PIPE_LAT-1];
    assign pipe_busy = |pv_q;
    // A result that cannot be delivered freezes everything behind it.
    assign head_blk  = head_vld & ~rq.rsp_rdy[head_tag];

    // Round-robin: scan from ptr_q upward; descending loop lets the lowest
    // offset overwrite, so the first valid at/after the pointer wins.
    always_comb begin
        win     = ptr_q;
        any_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rq.req_vld[(int'(ptr_q) + k) % N_REQ]) begin
                win     = TW'((int'(ptr_q) + k) % N_REQ);
                any_vld = 1'b1;
            end
        end
    end

    assign win_nxt = (win == TW'(N_REQ - 1)) ? '0 : win + 1'b1;

`ifdef SEC_A2B_SCRUB_EN
    localparam int CW = $clog2(PIPE_LAT);
    logic [CW-1:0] scnt_q, scnt_d;

    assign in_scrub = (state_q == S_SCRUB);

    always_comb begin
        scnt_d = '0;
        if (in_scrub) scnt_d = dp_ena ? scnt_q + 1'b1 : scnt_q;
    end
`else
    assign in_scrub = 1'b0;
`endif

    // Handshake / datapath drive. Everything is gated by rst so outputs are
    // quiet for the whole reset cycle, not just after it.
    always_comb begin
        dp_ena     = ~rst & rnd_vld & ~head_blk;
        issue      = dp_ena & any_vld & (state_q == S_RUN);
        rnd_take   = dp_ena & (issue | pipe_busy | in_scrub);
        dp_dvld    = issue;
        dp_a       = issue ? rq.req_a[win] : '0;
        rq.req_rdy = '0;
        if (issue) rq.req_rdy[win] = 1'b1;
        rq.rsp_vld = '0;
        rq.rsp_z   = '0;
        if (head_vld && !rst) begin
            rq.rsp_vld[head_tag] = 1'b1;
            rq.rsp_z             = dp_z;
        end
        flush_done = ~rst & (state_q == S_DONE);
        busy       = ~rst & (pipe_busy | (state_q != S_RUN));
        err        = ~rst & err_q;
    end

    // Next state for tag pipe, pointer, error flag and flush FSM.
    always_comb begin
        pv_d    = pv_q;
        pt_d    = pt_q;
        ptr_d   = issue ? win_nxt : ptr_q;
        err_d   = err_q | (dp_ena & (head_vld != dp_ovld));
        state_d = state_q;
        if (dp_ena) begin
            pv_d = {pv_q[PIPE_LAT-2:0], issue};
            pt_d = {pt_q[PIPE_LAT-2:0], (issue ? win : TW'(0))};
        end
        case (state_q)
            S_RUN:   if (flush) state_d = S_DRAIN;
`ifdef SEC_A2B_SCRUB_EN
            S_DRAIN: if (!pipe_busy) state_d = S_SCRUB;
            S_SCRUB: if (dp_ena && scnt_q == CW'(PIPE_LAT - 1)) state_d = S_DONE;
`else
            S_DRAIN: if (!pipe_busy) state_d = S_DONE;
`endif
            S_DONE:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pv_q    <= '0;
            pt_q    <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
`ifdef SEC_A2B_SCRUB_EN
            scnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pv_q    <= pv_d;
            pt_q    <= pt_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
`ifdef SEC_A2B_SCRUB_EN
            scnt_q  <= scnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sec_a2b_sched.sv
module tb_sec_a2b_sched;
    localparam int K  = 32;
    localparam int NS = 4;
    localparam int NR = 2;
    localparam int L  = 10;
    localparam int MW = K * NS;
`ifdef SEC_A2B_SCRUB_EN
    localparam int DRAIN_GAP = L + 2 + L;
`else
    localparam int DRAIN_GAP = L + 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          rnd_vld, rnd_take, dp_dvld, dp_ena, dp_ovld, flush, flush_done, busy, err;
    logic [MW-1:0] dp_a, dp_z;
    logic          force_ovld = 1'b0;

    sec_a2b_sched_if #(.N_REQ(NR), .MASKWIDTH(MW)) rq();

    sec_a2b_sched dut (
        .clk(clk), .rst(rst), .rq(rq),
        .rnd_vld(rnd_vld), .rnd_take(rnd_take),
        .dp_dvld(dp_dvld), .dp_ena(dp_ena), .dp_a(dp_a),
        .dp_ovld(dp_ovld), .dp_z(dp_z),
        .flush(flush), .flush_done(flush_done), .busy(busy), .err(err)
    );

    int n_pass = 0, n_tot = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [K-1:0] asum(input logic [MW-1:0] a);
        logic [K-1:0] s;
        s = '0;
        for (int j = 0; j < NS; j++) s += a[j*K +: K];
        return s;
    endfunction

    function automatic logic [K-1:0] bxor(input logic [MW-1:0] z);
        logic [K-1:0] s;
        s = '0;
        for (int j = 0; j < NS; j++) s ^= z[j*K +: K];
        return s;
    endfunction

    function automatic logic [MW-1:0] rand_op();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Boolean re-masking of the arithmetic sum with fresh random shares.
    function automatic logic [MW-1:0] a2b(input logic [MW-1:0] a);
        logic [K-1:0] s, m0, m1, m2;
        s = asum(a); m0 = $urandom; m1 = $urandom; m2 = $urandom;
        return {s ^ m0 ^ m1 ^ m2, m2, m1, m0};
    endfunction

    // Datapath stand-in: L-stage pipe that advances only with dp_ena.
    logic [L-1:0]  dm_v;
    logic [MW-1:0] dm_z [L];
    always @(posedge clk) begin
        if (rst) dm_v <= '0;
        else if (dp_ena) begin
            dm_v <= {dm_v[L-2:0], dp_dvld};
            for (int i = L - 1; i > 0; i--) dm_z[i] <= dm_z[i-1];
            dm_z[0] <= a2b(dp_a);
        end
    end
    assign dp_ovld = dm_v[L-1] | force_ovld;
    assign dp_z    = dm_z[L-1];

    // Reference model: in-order queue of issued ops and an RR pointer.
    typedef struct { int r; logic [MW-1:0] a; } op_t;
    op_t q[$];
    int  mptr = 0;

    initial begin : scoreboard
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                mptr = 0;
            end else begin
                if (rq.req_rdy != '0) begin
                    int w;
                    w = -1;
                    for (int k = NR - 1; k >= 0; k--)
                        if (rq.req_vld[(mptr + k) % NR]) w = (mptr + k) % NR;
                    if (w < 0) chk("sb_grant_without_vld", rq.req_rdy, '0);
                    else begin
                        chk("sb_grant_rr", rq.req_rdy, MW'(1) << w);
                        chk("sb_dp_a", dp_a, rq.req_a[w]);
                        q.push_back('{w, rq.req_a[w]});
                        mptr = (w + 1) % NR;
                    end
                end
                if (!dp_dvld) chk("sb_dp_a_idle", dp_a, '0);
                chk("sb_rnd_take", rnd_take & ~rnd_vld, '0);
                if (rq.rsp_vld != '0) begin
                    chk("sb_rsp_expected", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        chk("sb_rsp_vld", rq.rsp_vld, MW'(1) << q[0].r);
                        chk("sb_rsp_z", bxor(rq.rsp_z), asum(q[0].a));
                        if (rnd_vld && rq.rsp_rdy[q[0].r]) void'(q.pop_front());
                    end
                end else chk("sb_rsp_z_idle", rq.rsp_z, '0);
            end
        end
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic at_cyc(input int n); do @(negedge clk); while (cyc < n); endtask

    task automatic wait_rsp(input int maxc, output int got);
        got = -1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (rq.rsp_vld != '0) begin got = cyc; break; end
        end
    endtask

    task automatic wait_idle(input string nm);
        int ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk(nm, ok, 1);
        chk({nm, "_queue"}, q.size(), 0);
    endtask

    typedef struct { int r; logic [MW-1:0] a; logic [K-1:0] sum; } vec_t;
    vec_t tv[5];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int t0, got, popc, npulse, tdone, qsz, seen;
        logic [NR-1:0] g[8];
        logic [MW-1:0] z0;
        logic [NR-1:0] acc;

        tv[0] = '{0, {32'd4, 32'd3, 32'd2, 32'd1}, 32'd10};
        tv[1] = '{1, {32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF}, 32'd0};
        tv[2] = '{0, {32'd0, 32'd5, 32'h8000_0000, 32'h8000_0000}, 32'd5};
        tv[3] = '{1, {32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF}, 32'hDEAD_BEEF};
        tv[4] = '{0, {32'h40, 32'h30, 32'h20, 32'h10}, 32'hA0};

        // Reset with every input trying to provoke activity.
        rst = 1'b1; rnd_vld = 1'b1; flush = 1'b1;
        rq.req_vld = '1; rq.rsp_rdy = '1;
        rq.req_a[0] = rand_op(); rq.req_a[1] = rand_op();
        @(posedge clk); @(negedge clk);
        chk("rst_req_rdy", rq.req_rdy, '0);
        chk("rst_rsp_vld", rq.rsp_vld, '0);
        chk("rst_rsp_z", rq.rsp_z, '0);
        chk("rst_rnd_take", rnd_take, '0);
        chk("rst_dp_dvld", dp_dvld, '0);
        chk("rst_dp_ena", dp_ena, '0);
        chk("rst_dp_a", dp_a, '0);
        chk("rst_flush_done", flush_done, '0);
        chk("rst_busy", busy, '0);
        chk("rst_err", err, '0);
        step(); rst = 1'b0; flush = 1'b0; rq.req_vld = '0;

        // Table: single operations, fixed latency, arithmetic-to-Boolean value.
        for (int i = 0; i < 5; i++) begin
            step();
            rq.req_a[tv[i].r] = tv[i].a;
            rq.req_vld = '0; rq.req_vld[tv[i].r] = 1'b1;
            @(negedge clk);
            chk("tv_grant", rq.req_rdy, MW'(1) << tv[i].r);
            t0 = cyc;
            step(); rq.req_vld = '0;
            wait_rsp(40, got);
            chk("tv_latency", got - t0, L);
            chk("tv_rsp_vld", rq.rsp_vld, MW'(1) << tv[i].r);
            chk("tv_rsp_z", bxor(rq.rsp_z), tv[i].sum);
            chk("tv_err", err, '0);
        end

        // Both requesters continuously valid: grants and responses alternate.
        step();
        rq.req_vld = '1; rq.req_a[0] = rand_op(); rq.req_a[1] = rand_op();
        t0 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            g[k] = rq.req_rdy;
            if (k == 0) t0 = cyc;
            step();
            for (int i = 0; i < NR; i++) if (g[k][i]) rq.req_a[i] = rand_op();
        end
        rq.req_vld = '0;
        chk("alt_first_onehot", $onehot(g[0]), 1);
        for (int k = 1; k < 8; k++) chk("alt_grant", g[k], g[k-1] ^ 2'b11);
        for (int k = 0; k < 8; k++) begin
            at_cyc(t0 + L + k);
            chk("alt_rsp", rq.rsp_vld, g[k]);
        end
        wait_idle("alt_idle");

        // Backpressure: requester 1 withholds rsp_rdy while its result is head.
        step();
        rq.rsp_rdy = 2'b01; rq.req_vld = '1;
        rq.req_a[0] = rand_op(); rq.req_a[1] = rand_op();
        got = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rq.rsp_vld == 2'b10) begin got = cyc; break; end
        end
        chk("bp_reached_head", got >= 0, 1);
        z0 = rq.rsp_z;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_rsp_vld", rq.rsp_vld, 2'b10);
            chk("bp_rsp_z_stable", rq.rsp_z, z0);
            chk("bp_dp_ena", dp_ena, '0);
            chk("bp_no_grant", rq.req_rdy, '0);
        end
        step(); rq.rsp_rdy = '1; rq.req_vld = '0;
        wait_idle("bp_idle");

        // rnd_vld toggling: pipeline advances every other cycle.
        step();
        rnd_vld = 1'b1; rq.req_vld = 2'b01; rq.req_a[0] = rand_op();
        @(negedge clk);
        chk("tog_grant", rq.req_rdy, 2'b01);
        t0 = cyc; popc = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            rq.req_vld = '0; rnd_vld = (n % 2 == 0);
            @(negedge clk);
            if (rq.rsp_vld[0] && rnd_vld) begin popc = cyc; break; end
        end
        chk("tog_latency", popc - t0, 2 * L);
        step(); rnd_vld = 1'b1;
        wait_idle("tog_idle");

        // Flush with 3 ops in flight; flush coincides with the third issue.
        step();
        rq.req_vld = '1;
        for (int k = 0; k < 3; k++) begin
            flush = (k == 2);
            rq.req_a[0] = rand_op(); rq.req_a[1] = rand_op();
            @(negedge clk);
            chk("fl_issue", rq.req_rdy != '0, 1);
            t0 = cyc;
            step();
        end
        flush = 1'b0;
        npulse = 0; tdone = -1; qsz = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tdone < 0) begin
                chk("fl_drain_no_grant", rq.req_rdy, '0);
                chk("fl_drain_busy", busy, 1);
            end else if (cyc == tdone + 1) chk("fl_resume_grant", rq.req_rdy != '0, 1);
            if (flush_done) begin npulse++; tdone = cyc; qsz = q.size(); end
            step();
            if (tdone >= 0 && cyc > tdone + 1) rq.req_vld = '0;
        end
        chk("fl_pulses", npulse, 1);
        chk("fl_done_time", tdone - t0, DRAIN_GAP);
        chk("fl_all_delivered", qsz, 0);
        wait_idle("fl_idle");

        // Randomized traffic with backpressure and randomness starvation.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = rq.req_vld & rq.req_rdy;
            step();
            for (int i = 0; i < NR; i++)
                if (!rq.req_vld[i] || acc[i]) begin
                    rq.req_vld[i] = ($urandom_range(2) != 0);
                    rq.req_a[i]   = rand_op();
                end
            for (int i = 0; i < NR; i++) rq.rsp_rdy[i] = ($urandom_range(4) != 0);
            rnd_vld = ($urandom_range(3) != 0);
        end
        rq.req_vld = '0; rq.rsp_rdy = '1; rnd_vld = 1'b1;
        wait_idle("rand_idle");
        chk("rand_err", err, '0);

        // Reset with 4 results in flight: they must never surface.
        step();
        rq.req_vld = '1;
        repeat (4) begin @(negedge clk); step(); end
        rst = 1'b1; rq.req_vld = '0; rnd_vld = 1'b0;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_vld", rq.rsp_vld, '0);
        chk("mid_rst_rsp_z", rq.rsp_z, '0);
        chk("mid_rst_busy", busy, '0);
        chk("mid_rst_dp_ena", dp_ena, '0);
        chk("mid_rst_rnd_take", rnd_take, '0);
        chk("mid_rst_err", err, '0);
        step(); rnd_vld = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rq.rsp_vld != '0) seen++;
        end
        chk("mid_rst_no_stale_rsp", seen, 0);

        // dp_ovld high against an empty head sets sticky err until reset.
        step(); force_ovld = 1'b1;
        @(negedge clk);
        chk("err_before_edge", err, '0);
        step(); force_ovld = 1'b0;
        @(negedge clk);
        chk("err_set", err, 1);
        repeat (5) step();
        @(negedge clk);
        chk("err_sticky", err, 1);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_rst", err, '0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
